demux_rr_feeder: RTL and testbench

- Upstream stage for the 1-to-8 demultiplexer. Accepts a serial bit stream over a valid/ready handshake and drives the demux `in`/`sel` pair.
- Each accepted bit goes to the next enabled channel in round-robin order. The bit is held on the channel for a programmable dwell time.
- Output `in`/`sel` connect directly to the demux; the demux `Y[7:0]` is the final channel fan-out.

---
 rtl/demux_pkg.sv | 12 +
 rtl/rr_next_enabled.sv | 35 +++
 rtl/demux_rr_feeder.sv | 89 ++++++++
 tb/tb_demux_rr_feeder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and FSM encoding for the demux feeder and its helpers.
package demux_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/rr_next_enabled.sv
// Combinational round-robin search: first enabled channel at or after start,
// wrapping past the top, plus a flag when no enabled channel lies above it.
module rr_next_enabled
    import demux_pkg::*;
(
    input  logic [NCH-1:0]   mask,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] target,
    output logic             found,
    output logic             is_last
);

    always_comb begin
        logic [SEL_W-1:0] idx;
        target  = '0;
        found   = 1'b0;
        is_last = 1'b0;
        idx     = '0;
        for (int i = 0; i < NCH; i++) begin
            // Index arithmetic is SEL_W wide, so the 7 -> 0 wrap is free.
            idx = start + SEL_W'(i);
            if (!found && mask[idx]) begin
                found  = 1'b1;
                target = idx;
            end
        end
        is_last = found;
        for (int j = 0; j < NCH; j++) begin
            if ((j > int'(target)) && mask[j]) begin
                is_last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/demux_rr_feeder.sv
// Serial-to-demux feeder: accepts bits over valid/ready and holds each one on
// the next enabled channel (round-robin) for a programmable dwell time.
module demux_rr_feeder
    import demux_pkg::state_t, demux_pkg::IDLE, demux_pkg::HOLD;
#(
    parameter int NCH     = 8,
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     ch_en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               data_in,
    input  logic               data_valid,
    output logic               data_ready,
    output logic               in,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               frame_done
);

    state_t             state;
    state_t             state_next;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   target;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_m1;
    logic               found;
    logic               is_last;
    logic               accept;

    rr_next_enabled u_next (
        .mask    (ch_en),
        .start   (ptr),
        .target  (target),
        .found   (found),
        .is_last (is_last)
    );

    // found is equivalent to ch_en != 0; a pending bit simply waits while no channel is enabled.
    assign data_ready = ((state == IDLE) || ((state == HOLD) && (cnt == '0))) && found;
    assign accept     = data_valid && data_ready;
    assign dwell_m1   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    assign busy       = (state == HOLD);

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = HOLD;
        end else if ((state == HOLD) && (cnt == '0)) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            cnt        <= '0;
            in         <= 1'b0;
            sel        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && is_last;
            if (accept) begin
                in  <= data_in;
                sel <= target;
                cnt <= dwell_m1;
                ptr <= target + SEL_W'(1);
            end else if (state == HOLD) begin
                // Last hold cycle without a follow-on bit: drop data, keep sel.
                if (cnt != '0) begin
                    cnt <= cnt - DWELL_W'(1);
                end else begin
                    in <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_rr_feeder.sv
// Randomised scoreboard bench for demux_rr_feeder with directed scenarios first.
module tb_demux_rr_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ch_en;
    logic [3:0] dwell;
    logic       data_in;
    logic       data_valid;
    logic       data_ready;
    logic       in_bit;
    logic [2:0] sel;
    logic       busy;
    logic       frame_done;

    demux_rr_feeder #(.NCH(8), .SEL_W(3), .DWELL_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_en      (ch_en),
        .dwell      (dwell),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .in         (in_bit),
        .sel        (sel),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic b;
        int   ch;
        int   hold;
        logic fd;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   mon_left   = 0;
    int   m_ptr      = 0;
    int   m_hold     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int find_target(input logic [7:0] m, input int p);
        for (int i = 0; i < 8; i++) begin
            if (m[(p + i) % 8]) return (p + i) % 8;
        end
        return -1;
    endfunction

    function automatic logic last_of(input logic [7:0] m, input int t);
        return ((32'(m) >> (t + 1)) == 32'd0);
    endfunction

    // Called at posedge+1; returns at the following posedge+1.
    task automatic tick(input logic v, input logic d);
        exp_t e;
        int   t;
        logic rdy;
        logic acc;
        data_valid = v;
        data_in    = d;
        #1;
        rdy = (m_hold <= 1) && (ch_en != 8'h00);
        chk("data_ready", 32'(data_ready), 32'(rdy));
        acc = v && rdy;
        @(posedge clk);
        if (acc) begin
            t      = find_target(ch_en, m_ptr);
            e.b    = d;
            e.ch   = t;
            e.hold = (dwell == 4'd0) ? 1 : int'(dwell);
            e.fd   = last_of(ch_en, t);
            q.push_back(e);
            m_ptr  = (t + 1) % 8;
            m_hold = e.hold;
        end else if (m_hold > 0) begin
            m_hold--;
        end
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        data_valid = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_ptr  = 0;
        m_hold = 0;
    endtask

    // Monitor: samples on the falling edge and walks the expected hold sequence.
    initial begin
        exp_t       cur;
        int         left;
        logic       first;
        logic       r;
        logic [2:0] last_sel;
        left     = 0;
        first    = 1'b0;
        last_sel = 3'd0;
        cur      = '{b: 1'b0, ch: 0, hold: 0, fd: 1'b0};
        forever begin
            @(posedge clk);
            r = rst;
            @(negedge clk);
            if (r) begin
                q.delete();
                left     = 0;
                last_sel = 3'd0;
                chk("reset_in", 32'(in_bit), 32'd0);
                chk("reset_sel", 32'(sel), 32'd0);
                chk("reset_busy", 32'(busy), 32'd0);
                chk("reset_frame_done", 32'(frame_done), 32'd0);
            end else begin
                if (left == 0 && q.size() > 0) begin
                    cur   = q.pop_front();
                    left  = cur.hold;
                    first = 1'b1;
                end
                if (left > 0) begin
                    chk("hold_in", 32'(in_bit), 32'(cur.b));
                    chk("hold_sel", 32'(sel), 32'(cur.ch));
                    chk("hold_busy", 32'(busy), 32'd1);
                    chk("frame_done", 32'(frame_done), 32'(first && cur.fd));
                    first    = 1'b0;
                    left--;
                    last_sel = 3'(cur.ch);
                end else begin
                    chk("idle_in", 32'(in_bit), 32'd0);
                    chk("idle_busy", 32'(busy), 32'd0);
                    chk("idle_frame_done", 32'(frame_done), 32'd0);
                    chk("idle_sel", 32'(sel), 32'(last_sel));
                end
            end
            mon_left = left;
        end
    end

    initial begin
        logic bits [8];
        bits       = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = 1'b0;
        ch_en      = 8'hFF;
        dwell      = 4'd1;
        do_reset();

        // Full rotation, one cycle per bit.
        for (int i = 0; i < 8; i++) tick(1'b1, bits[i]);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);

        // Sparse mask 2,5,7.
        ch_en = 8'b1010_0100;
        for (int i = 0; i < 6; i++) tick(1'b1, 1'($urandom));
        tick(1'b0, 1'b0);

        // Multi-cycle dwell, then dwell 0 behaves as 1.
        ch_en = 8'hFF;
        dwell = 4'd3;
        for (int i = 0; i < 6; i++) tick(1'b1, 1'(i[0]));
        tick(1'b0, 1'b0);
        dwell = 4'd0;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);

        // No channel enabled stalls, then a single channel takes the bit.
        ch_en = 8'h00;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
        ch_en = 8'h10;
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);

        // Mask change during a hold on channel 3.
        do_reset();
        ch_en = 8'hFF;
        dwell = 4'd1;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        dwell = 4'd4;
        tick(1'b1, 1'b1);
        ch_en = 8'h01;
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);

        // Reset in the middle of a hold.
        ch_en = 8'hFF;
        dwell = 4'd4;
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        do_reset();
        dwell = 4'd1;
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                ch_en = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            end
            dwell = 4'($urandom_range(0, 3));
            tick(($urandom_range(0, 3) != 0), 1'($urandom));
        end

        ch_en = 8'hFF;
        for (int i = 0; i < 100 && (q.size() != 0 || mon_left != 0); i++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("drain", 32'(q.size() + mon_left), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
